slc3_control_unit: RTL

Parametrised SLC-3 instruction sequencing and decode unit (next-generation ISDU). It drives all datapath load, gate, mux, ALU and memory strobes for the full SLC-3 subset: ADD, AND, NOT, BR, JMP, JSR/JSRR, LDR, STR and PAUSE. Memory read and write wait states are counted by a single shared timer set by parameters, not by hand-unrolled states. It sits between the IR/BEN logic and the SLC-3 datapath plus BRAM.

---
 rtl/slc3_pkg.sv | 77 +++++++
 rtl/slc3_control_unit_timer.sv | 37 +++
 rtl/slc3_control_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/slc3_pkg.sv
// Shared types and encodings for the SLC-3 instruction sequencing and decode unit.
package slc3_pkg;

    typedef enum logic [4:0] {
        HALTED,
        S_18,
        S_33,
        S_35,
        PAUSE_IR1,
        PAUSE_IR2,
        S_32,
        S_01,
        S_05,
        S_09,
        S_00,
        S_22,
        S_12,
        S_04,
        S_21,
        S_20,
        S_06,
        S_07,
        S_25,
        S_27,
        S_23,
        S_16,
        S_P1,
        S_P2
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_PC1  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    localparam logic [1:0] ADDR2_ZERO   = 2'b00;
    localparam logic [1:0] ADDR2_SEXT6  = 2'b01;
    localparam logic [1:0] ADDR2_SEXT9  = 2'b10;
    localparam logic [1:0] ADDR2_SEXT11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    // First execute state for an opcode; unknown opcodes fall back to the next fetch.
    function automatic state_t decode_opcode(input logic [3:0] op);
        state_t s;
        case (op)
            OP_ADD:   s = S_01;
            OP_AND:   s = S_05;
            OP_NOT:   s = S_09;
            OP_BR:    s = S_00;
            OP_JMP:   s = S_12;
            OP_JSR:   s = S_04;
            OP_LDR:   s = S_06;
            OP_STR:   s = S_07;
            OP_PAUSE: s = S_P1;
            default:  s = S_18;
        endcase
        return s;
    endfunction

    function automatic logic is_wait_state(input state_t s);
        return (s == S_33) || (s == S_25) || (s == S_16);
    endfunction

endpackage

// File: rtl/slc3_control_unit_timer.sv
// Shared memory wait-state counter: clear on entry, count while waiting, flag the last cycle.
module slc3_wait_timer #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned RD_LIMIT = 3,
    parameter int unsigned WR_LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic wr_sel,
    output logic done_c
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    assign done_c = (count_q == (wr_sel ? WIDTH'(WR_LIMIT - 1) : WIDTH'(RD_LIMIT - 1)));

endmodule

// File: rtl/slc3_control_unit.sv
// SLC-3 instruction sequencing and decode unit: Moore FSM driving datapath strobes,
// with memory wait states counted by one shared timer.
module slc3_control_unit
    import slc3_pkg::*;
#(
    parameter int unsigned MEM_RD_WAIT       = 3,
    parameter int unsigned MEM_WR_WAIT       = 3,
    parameter int unsigned PAUSE_AFTER_FETCH = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam int unsigned MAX_WAIT = (MEM_RD_WAIT > MEM_WR_WAIT) ? MEM_RD_WAIT : MEM_WR_WAIT;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

    state_t state_q;
    state_t state_d;
    logic   wait_clr_c;
    logic   wait_en_c;
    logic   wait_wr_sel_c;
    logic   wait_done_c;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    // Restart the count on every fresh entry into a memory wait state.
    assign wait_en_c     = is_wait_state(state_q);
    assign wait_clr_c    = is_wait_state(state_d) && (state_d != state_q);
    assign wait_wr_sel_c = (state_q == S_16);

    slc3_wait_timer #(
        .WIDTH    (CNT_W),
        .RD_LIMIT (MEM_RD_WAIT),
        .WR_LIMIT (MEM_WR_WAIT)
    ) u_wait_timer (
        .clk    (Clk),
        .rst    (Reset),
        .clr    (wait_clr_c),
        .en     (wait_en_c),
        .wr_sel (wait_wr_sel_c),
        .done_c (wait_done_c)
    );

    always_comb begin
        state_d    = state_q;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_PC1;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_ZERO;
        ALUK       = ALUK_ADD;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;

        case (state_q)
            HALTED: begin
                if (Run) state_d = S_18;
            end
            S_18: begin
                GatePC  = 1'b1;
                LD_MAR  = 1'b1;
                LD_PC   = 1'b1;
                PCMUX   = PCMUX_PC1;
                state_d = S_33;
            end
            S_33: begin
                Mem_OE = 1'b1;
                LD_MDR = 1'b1;
                if (wait_done_c) state_d = S_35;
            end
            S_35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                state_d = (PAUSE_AFTER_FETCH != 0) ? PAUSE_IR1 : S_32;
            end
            PAUSE_IR1: begin
                LD_LED = 1'b1;
                if (Continue) state_d = PAUSE_IR2;
            end
            PAUSE_IR2: begin
                LD_LED = 1'b1;
                if (!Continue) state_d = S_18;
            end
            S_32: begin
                LD_BEN  = 1'b1;
                state_d = decode_opcode(Opcode);
            end
            S_01, S_05: begin
                SR2MUX  = IR_5;
                SR1MUX  = 1'b1;
                ALUK    = (state_q == S_05) ? ALUK_AND : ALUK_ADD;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                DRMUX   = 1'b0;
                state_d = S_18;
            end
            S_09: begin
                SR1MUX  = 1'b1;
                ALUK    = ALUK_NOT;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = S_18;
            end
            S_00: begin
                state_d = BEN ? S_22 : S_18;
            end
            S_22: begin
                ADDR1MUX = 1'b0;
                ADDR2MUX = ADDR2_SEXT9;
                PCMUX    = PCMUX_ADDR;
                LD_PC    = 1'b1;
                state_d  = S_18;
            end
            S_12, S_20: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                ADDR2MUX = ADDR2_ZERO;
                PCMUX    = PCMUX_ADDR;
                LD_PC    = 1'b1;
                state_d  = S_18;
            end
            S_04: begin
                GatePC  = 1'b1;
                DRMUX   = 1'b1;
                LD_REG  = 1'b1;
                state_d = IR_11 ? S_21 : S_20;
            end
            S_21: begin
                ADDR1MUX = 1'b0;
                ADDR2MUX = ADDR2_SEXT11;
                PCMUX    = PCMUX_ADDR;
                LD_PC    = 1'b1;
                state_d  = S_18;
            end
            S_06, S_07: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2_SEXT6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_d    = (state_q == S_06) ? S_25 : S_23;
            end
            S_25: begin
                Mem_OE = 1'b1;
                LD_MDR = 1'b1;
                if (wait_done_c) state_d = S_27;
            end
            S_27: begin
                GateMDR = 1'b1;
                DRMUX   = 1'b0;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = S_18;
            end
            // Store data goes through the ALU pass-through into MDR, memory output disabled.
            S_23: begin
                SR1MUX  = 1'b0;
                ALUK    = ALUK_PASSA;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                Mem_OE  = 1'b0;
                state_d = S_16;
            end
            S_16: begin
                Mem_WE = 1'b1;
                if (wait_done_c) state_d = S_18;
            end
            S_P1: begin
                LD_LED = 1'b1;
                if (Continue) state_d = S_P2;
            end
            S_P2: begin
                LD_LED = 1'b1;
                if (!Continue) state_d = S_18;
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

endmodule
